// File: rtl/btb_pkg.sv
// Shared BTB definitions: default widths, 2-bit counter encodings and PC field helpers.
package btb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IDX_W  = 6;
  localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  function automatic logic [DEF_IDX_W-1:0] pc_idx(input logic [DEF_ADDR_W-1:0] pc);
    return pc[DEF_IDX_W+1:2];
  endfunction

  function automatic logic [DEF_TAG_W-1:0] pc_tag(input logic [DEF_ADDR_W-1:0] pc);
    return pc[DEF_ADDR_W-1:DEF_IDX_W+2];
  endfunction

endpackage

// File: rtl/btb_update_writer_if.sv
// Signal bundle between the EX branch resolver, the update writer and the BTB array ports.
interface btb_update_writer_if
  import btb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) ();

  // Handshakes: res_* transfers on a cycle with res_valid && res_ready; btb_rd_en is a
  // one-cycle request whose btb_rd_* data is valid the following cycle; btb_wr_en and
  // its data stay stable until the cycle with btb_wr_grant, which completes the write.
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_pc;
  logic [ADDR_W-1:0] res_target;
  logic              res_taken;

  logic              btb_rd_en;
  logic [IDX_W-1:0]  btb_rd_idx;
  logic              btb_rd_vld;
  logic [TAG_W-1:0]  btb_rd_tag;
  logic [1:0]        btb_rd_ctr;

  logic              btb_wr_en;
  logic              btb_wr_grant;
  logic [IDX_W-1:0]  btb_wr_idx;
  logic [TAG_W-1:0]  btb_wr_tag;
  logic [ADDR_W-1:0] btb_wr_target;
  logic [1:0]        btb_wr_ctr;

  modport slave (
    input  res_valid, res_pc, res_target, res_taken,
    output res_ready,
    output btb_rd_en, btb_rd_idx,
    input  btb_rd_vld, btb_rd_tag, btb_rd_ctr,
    output btb_wr_en, btb_wr_idx, btb_wr_tag, btb_wr_target, btb_wr_ctr,
    input  btb_wr_grant
  );

  modport master (
    output res_valid, res_pc, res_target, res_taken,
    input  res_ready,
    input  btb_rd_en, btb_rd_idx,
    output btb_rd_vld, btb_rd_tag, btb_rd_ctr,
    input  btb_wr_en, btb_wr_idx, btb_wr_tag, btb_wr_target, btb_wr_ctr,
    output btb_wr_grant
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// In-order queue of resolved branches awaiting their BTB read-modify-write.
module btb_upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_writer.sv
// BTB write side: queues EX-resolved branches and read-modify-writes the indexed entry.
// Optional BTB_UPD_STATS_EN adds stat_upd/stat_alloc/stat_drop event counters.
module btb_update_writer
  import btb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = ADDR_W - IDX_W - 2,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  btb_update_writer_if.slave u,
  output logic               busy,
  output logic [1:0]         dbg_state
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [15:0]        stat_upd,
  output logic [15:0]        stat_alloc,
  output logic [15:0]        stat_drop
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam int PCW_W = ADDR_W - 2;
  localparam int ENT_W = PCW_W + ADDR_W + 1;

  state_t            state;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_din;
  logic [ENT_W-1:0]  fifo_dout;
  logic [PCW_W-1:0]  head_pcw;
  logic [ADDR_W-1:0] head_target;
  logic              head_taken;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [ADDR_W-1:0] w_target;
  logic              w_taken;

  logic              rd_en;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [ADDR_W-1:0] wr_target;
  logic [1:0]        wr_ctr;

  logic              hit;
  logic              alloc;
  logic              drop;
  logic              granted;
  logic              pc_lsb_unused;

  // Instructions are word aligned, so the two PC LSBs carry no index or tag information.
  assign pc_lsb_unused = ^u.res_pc[1:0];

  assign fifo_push = u.res_valid && !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fifo_din  = {u.res_pc[ADDR_W-1:2], u.res_target, u.res_taken};
  assign {head_pcw, head_target, head_taken} = fifo_dout;

  btb_upd_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hit     = u.btb_rd_vld && (u.btb_rd_tag == w_tag);
  assign alloc   = (state == CMP) && !hit && w_taken;
  assign drop    = (state == CMP) && !hit && !w_taken;
  assign granted = (state == WR) && u.btb_wr_grant;

  // Read data arrives in CMP, one cycle after rd_en; the next pop waits for the write
  // grant so a following update to the same index reads the freshly written entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_idx     <= '0;
      w_tag     <= '0;
      w_target  <= '0;
      w_taken   <= 1'b0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_tag    <= '0;
      wr_target <= '0;
      wr_ctr    <= CTR_SNT;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            w_idx    <= head_pcw[IDX_W-1:0];
            w_tag    <= head_pcw[PCW_W-1:IDX_W];
            w_target <= head_target;
            w_taken  <= head_taken;
            rd_en    <= 1'b1;
            state    <= RD;
          end
        end
        RD: begin
          rd_en <= 1'b0;
          state <= CMP;
        end
        CMP: begin
          if (hit || w_taken) begin
            wr_en     <= 1'b1;
            wr_idx    <= w_idx;
            wr_tag    <= w_tag;
            wr_target <= w_target;
            wr_ctr    <= !hit ? CTR_WT
                       : (w_taken ? sat_inc(u.btb_rd_ctr) : sat_dec(u.btb_rd_ctr));
            state     <= WR;
          end else begin
            state <= IDLE;
          end
        end
        WR: begin
          if (u.btb_wr_grant) begin
            wr_en <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign u.res_ready     = !fifo_full;
  assign u.btb_rd_en     = rd_en;
  assign u.btb_rd_idx    = w_idx;
  assign u.btb_wr_en     = wr_en;
  assign u.btb_wr_idx    = wr_idx;
  assign u.btb_wr_tag    = wr_tag;
  assign u.btb_wr_target = wr_target;
  assign u.btb_wr_ctr    = wr_ctr;

  assign busy      = !fifo_empty || (state != IDLE);
  assign dbg_state = state;

`ifdef BTB_UPD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd   <= '0;
      stat_alloc <= '0;
      stat_drop  <= '0;
    end else begin
      if (granted) stat_upd   <= stat_upd + 16'd1;
      if (alloc)   stat_alloc <= stat_alloc + 16'd1;
      if (drop)    stat_drop  <= stat_drop + 16'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = granted ^ alloc ^ drop;
`endif

endmodule
